parking_gate_ctrl: RTL and testbench



---
 rtl/parking_pkg.sv | 32 +++
 rtl/parking_occupancy_counter.sv | 42 ++++
 rtl/parking_gate_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared definitions for the parking gate controller: FSM state encoding,
// 7-segment glyphs (active-low, bit order {g,f,e,d,c,b,a}) and a helper
// that tells which states drive a blinking LED.
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        WAIT_PASSWORD = 3'd1,
        WRONG_PASS    = 3'd2,
        RIGHT_PASS    = 3'd3,
        STOP          = 3'd4,
        LOCKOUT       = 3'd5,
        FULL          = 3'd6
    } state_e;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [6:0] SEG_E   = 7'b0000110;
    localparam logic [6:0] SEG_n   = 7'b0101011;
    localparam logic [6:0] SEG_G   = 7'b0000010;
    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_P   = 7'b0001100;
    localparam logic [6:0] SEG_L   = 7'b1000111;
    localparam logic [6:0] SEG_C   = 7'b1000110;
    localparam logic [6:0] SEG_F   = 7'b0001110;

    // States whose indicator LED blinks rather than being steady.
    function automatic logic is_blink_state(input state_e s);
        return (s == WRONG_PASS) || (s == RIGHT_PASS) || (s == STOP) || (s == FULL);
    endfunction

endpackage

// File: rtl/parking_occupancy_counter.sv
// Saturating up/down count of cars inside the lot. An admission and a
// departure in the same cycle cancel out; the count never leaves
// 0..CAPACITY.
module parking_occupancy_counter #(
    parameter int CAPACITY = 8,
    parameter int OCC_W    = $clog2(CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             admit,
    input  logic             leave,
    output logic [OCC_W-1:0] occupancy,
    output logic             lot_full
);

    localparam logic [OCC_W-1:0] CAP_V = OCC_W'(CAPACITY);

    logic [OCC_W-1:0] occ_q, occ_d;

    // Next count: increment on admit, decrement on leave, both -> hold.
    always_comb begin
        occ_d = occ_q;
        if (admit && !leave && (occ_q != CAP_V)) begin
            occ_d = occ_q + 1'b1;
        end else if (leave && !admit && (occ_q != '0)) begin
            occ_d = occ_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;
    assign lot_full  = (occ_q == CAP_V);

endmodule

// File: rtl/parking_gate_ctrl.sv
// Single-gate parking controller: password entry with retries, timeout and
// lockout, occupancy tracking with a FULL refusal, and a registered LED /
// 7-segment front panel that follows the FSM state one cycle later.
//
// pass_valid is a one-cycle strobe with no back-pressure: password_1 and
// password_2 are sampled only in the cycle pass_valid is high, and only in
// WAIT_PASSWORD, WRONG_PASS and STOP; every other cycle/state ignores them.
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int              CAPACITY    = 8,
    parameter int              PW_W        = 2,
    parameter logic [PW_W-1:0] PASS_1      = 2'b01,
    parameter logic [PW_W-1:0] PASS_2      = 2'b10,
    parameter int              MAX_TRIES   = 3,
    parameter int              TIMEOUT     = 32,
    parameter int              LOCK_CYCLES = 16,
    parameter int              BLINK_DIV   = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             sensor_entrance,
    input  logic                             sensor_exit,
    input  logic                             car_leave,
    input  logic                             pass_valid,
    input  logic [PW_W-1:0]                  password_1,
    input  logic [PW_W-1:0]                  password_2,
    output logic                             GREEN_LED,
    output logic                             RED_LED,
    output logic [6:0]                       HEX_1,
    output logic [6:0]                       HEX_2,
    output logic [$clog2(CAPACITY+1)-1:0]    occupancy,
    output logic                             lot_full,
    output logic [2:0]                       state_dbg
);

    localparam int OCC_W   = $clog2(CAPACITY + 1);
    localparam int TMR_MAX = (TIMEOUT > LOCK_CYCLES) ? TIMEOUT : LOCK_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int TRY_W   = $clog2(MAX_TRIES + 1);
    localparam int BLK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] LOCK_LAST    = TMR_W'(LOCK_CYCLES - 1);
    localparam logic [TRY_W-1:0] TRIES_LIMIT  = TRY_W'(MAX_TRIES);
    localparam logic [BLK_W-1:0] BLINK_LAST   = BLK_W'(BLINK_DIV - 1);

    state_e           state_q, state_d;
    logic [TRY_W-1:0] tries_q, tries_d, tries_inc;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             match, admit;

    // Front-panel registers; shown_q is the state the panel currently shows.
    state_e           shown_q;
    logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_led_q, blink_led_d;
    logic             green_q, green_d, red_q, red_d;
    logic [6:0]       hex1_q, hex1_d, hex2_q, hex2_d;

    assign match     = pass_valid && (password_1 == PASS_1) && (password_2 == PASS_2);
    assign tries_inc = tries_q + 1'b1;

    // Next-state logic: transitions, retry bookkeeping and the shared timer.
    always_comb begin
        state_d = state_q;
        tries_d = tries_q;
        timer_d = timer_q;
        admit   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sensor_entrance) begin
                    if (lot_full) begin
                        state_d = FULL;
                    end else begin
                        state_d = WAIT_PASSWORD;
                        tries_d = '0;
                        timer_d = '0;
                    end
                end
            end
            WAIT_PASSWORD, WRONG_PASS: begin
                if (state_q == WAIT_PASSWORD) begin
                    timer_d = timer_q + 1'b1;
                end
                if (match) begin
                    state_d = RIGHT_PASS;
                end else if (pass_valid) begin
                    tries_d = tries_inc;
                    if (tries_inc == TRIES_LIMIT) begin
                        state_d = LOCKOUT;
                        timer_d = '0;
                    end else begin
                        state_d = WRONG_PASS;
                    end
                end else if ((state_q == WAIT_PASSWORD) && (timer_q == TIMEOUT_LAST)) begin
                    state_d = IDLE;
                end
            end
            LOCKOUT: begin
                if (timer_q == LOCK_LAST) begin
                    state_d = IDLE;
                    tries_d = '0;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RIGHT_PASS: begin
                if (sensor_exit) begin
                    if (sensor_entrance) begin
                        state_d = STOP;
                    end else begin
                        state_d = IDLE;
                        admit   = 1'b1;
                    end
                end
            end
            STOP: begin
                if (match) begin
                    state_d = RIGHT_PASS;
                end
            end
            FULL: begin
                if (!sensor_entrance || !lot_full) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, retry count and timer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tries_q <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            tries_q <= tries_d;
            timer_q <= timer_d;
        end
    end

    // Panel decode: blink divider restarts with the LED lit on state entry.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_led_d = blink_led_q;
        green_d     = 1'b0;
        red_d       = 1'b0;
        hex1_d      = SEG_OFF;
        hex2_d      = SEG_OFF;
        if ((state_q != shown_q) && is_blink_state(state_q)) begin
            blink_cnt_d = '0;
            blink_led_d = 1'b1;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_led_d = ~blink_led_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end
        unique case (state_q)
            WAIT_PASSWORD: begin red_d = 1'b1;        hex1_d = SEG_E; hex2_d = SEG_n; end
            WRONG_PASS:    begin red_d = blink_led_d; hex1_d = SEG_E; hex2_d = SEG_E; end
            RIGHT_PASS:  begin green_d = blink_led_d; hex1_d = SEG_G; hex2_d = SEG_0; end
            STOP:          begin red_d = blink_led_d; hex1_d = SEG_5; hex2_d = SEG_P; end
            LOCKOUT:       begin red_d = 1'b1;        hex1_d = SEG_L; hex2_d = SEG_C; end
            FULL:          begin red_d = blink_led_d; hex1_d = SEG_F; hex2_d = SEG_L; end
            default: begin end
        endcase
    end

    // Panel registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shown_q     <= IDLE;
            blink_cnt_q <= '0;
            blink_led_q <= 1'b0;
            green_q     <= 1'b0;
            red_q       <= 1'b0;
            hex1_q      <= SEG_OFF;
            hex2_q      <= SEG_OFF;
        end else begin
            shown_q     <= state_q;
            blink_cnt_q <= blink_cnt_d;
            blink_led_q <= blink_led_d;
            green_q     <= green_d;
            red_q       <= red_d;
            hex1_q      <= hex1_d;
            hex2_q      <= hex2_d;
        end
    end

    parking_occupancy_counter #(
        .CAPACITY (CAPACITY),
        .OCC_W    (OCC_W)
    ) u_occ (
        .clk       (clk),
        .reset     (reset),
        .admit     (admit),
        .leave     (car_leave),
        .occupancy (occupancy),
        .lot_full  (lot_full)
    );

    assign GREEN_LED = green_q;
    assign RED_LED   = red_q;
    assign HEX_1     = hex1_q;
    assign HEX_2     = hex2_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl (CAPACITY=2, BLINK_DIV=4). Expected
// panel/state/occupancy values are queued before each stimulus step and
// popped against the DUT #1 after the following clock edge.
module tb_parking_gate_ctrl;

    localparam int W = 22;

    localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_WRONG = 3'd2, S_RIGHT = 3'd3,
                           S_STOP = 3'd4, S_LOCK = 3'd5, S_FULL = 3'd6;

    localparam logic [6:0] H_OFF = 7'b1111111, H_E = 7'b0000110, H_N = 7'b0101011,
                           H_G = 7'b0000010, H_O = 7'b1000000, H_S = 7'b0010010,
                           H_P = 7'b0001100, H_L = 7'b1000111, H_C = 7'b1000110,
                           H_F = 7'b0001110;

    localparam logic [W-1:0] M_ST  = {3'b111, 19'b0};
    localparam logic [W-1:0] M_OUT = {3'b000, 1'b1, 1'b1, 7'h7f, 7'h7f, 3'b000};
    localparam logic [W-1:0] M_OCC = {19'b0, 2'b11, 1'b1};

    // clock / reset and DUT signals
    logic       clk = 1'b0;
    logic       reset;
    logic       sensor_entrance, sensor_exit, car_leave, pass_valid;
    logic [1:0] password_1, password_2;
    logic       green_led, red_led, lot_full;
    logic [6:0] hex_1, hex_2;
    logic [1:0] occupancy;
    logic [2:0] state_dbg;
    logic [W-1:0] obs;

    always #5 clk = ~clk;

    parking_gate_ctrl #(
        .CAPACITY    (2),
        .PW_W        (2),
        .PASS_1      (2'b01),
        .PASS_2      (2'b10),
        .MAX_TRIES   (3),
        .TIMEOUT     (32),
        .LOCK_CYCLES (16),
        .BLINK_DIV   (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .sensor_entrance (sensor_entrance),
        .sensor_exit     (sensor_exit),
        .car_leave       (car_leave),
        .pass_valid      (pass_valid),
        .password_1      (password_1),
        .password_2      (password_2),
        .GREEN_LED       (green_led),
        .RED_LED         (red_led),
        .HEX_1           (hex_1),
        .HEX_2           (hex_2),
        .occupancy       (occupancy),
        .lot_full        (lot_full),
        .state_dbg       (state_dbg)
    );

    assign obs = {state_dbg, green_led, red_led, hex_1, hex_2, occupancy, lot_full};

    // scoreboard
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mask_q[$];
    string        tag_q[$];
    int           checks   = 0;
    int           failures = 0;

    task automatic exp_state(input string t, input logic [2:0] s);
        exp_q.push_back({s, 19'b0});
        mask_q.push_back(M_ST);
        tag_q.push_back(t);
    endtask

    task automatic exp_out(input string t, input logic g, input logic r,
                           input logic [6:0] h1, input logic [6:0] h2);
        exp_q.push_back({3'b000, g, r, h1, h2, 3'b000});
        mask_q.push_back(M_OUT);
        tag_q.push_back(t);
    endtask

    task automatic exp_occ(input string t, input logic [1:0] o, input logic f);
        exp_q.push_back({19'b0, o, f});
        mask_q.push_back(M_OCC);
        tag_q.push_back(t);
    endtask

    task automatic check();
        logic [W-1:0] e, m;
        string        t;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            m = mask_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            assert ((obs & m) === (e & m)) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", t, obs & m, e & m);
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [1:0] p1, input logic [1:0] p2);
        pass_valid = 1'b1;
        password_1 = p1;
        password_2 = p2;
    endtask

    initial begin
        reset = 1'b1;
        sensor_entrance = 1'b0; sensor_exit = 1'b0; car_leave = 1'b0;
        pass_valid = 1'b0; password_1 = 2'b00; password_2 = 2'b00;

        // reset values
        exp_state("rst_state", S_IDLE);
        exp_out("rst_panel", 1'b0, 1'b0, H_OFF, H_OFF);
        exp_occ("rst_occ", 2'd0, 1'b0);
        cyc(2);
        reset = 1'b0;
        check();

        // correct entry and admission
        sensor_entrance = 1'b1;
        exp_state("s1_wait", S_WAIT);
        cyc(1); check();
        exp_out("s1_en", 1'b0, 1'b1, H_E, H_N);
        cyc(1); check();
        cyc(1);
        sensor_entrance = 1'b0;
        strobe(2'b01, 2'b10);
        exp_state("s1_right", S_RIGHT);
        cyc(1); pass_valid = 1'b0; check();
        exp_out("s1_go", 1'b1, 1'b0, H_G, H_O);
        cyc(1); check();
        sensor_exit = 1'b1;
        exp_state("s1_idle", S_IDLE);
        cyc(1); sensor_exit = 1'b0; check();
        exp_occ("s1_occ", 2'd1, 1'b0);
        exp_out("s1_off", 1'b0, 1'b0, H_OFF, H_OFF);
        cyc(1); check();

        // three wrong submissions -> lockout, correct strobes ignored
        sensor_entrance = 1'b1;
        cyc(1);
        sensor_entrance = 1'b0;
        strobe(2'b00, 2'b00);
        exp_state("s2_wrong", S_WRONG);
        cyc(1); pass_valid = 1'b0; check();
        exp_out("s2_ee", 1'b0, 1'b1, H_E, H_E);
        cyc(1); check();
        strobe(2'b00, 2'b00);
        exp_state("s2_wrong2", S_WRONG);
        cyc(1); check();
        exp_state("s2_lock", S_LOCK);
        cyc(1); check();
        strobe(2'b01, 2'b10);
        exp_out("s2_lc", 1'b0, 1'b1, H_L, H_C);
        cyc(1); check();
        cyc(13);
        exp_state("s2_lock_last", S_LOCK);
        exp_out("s2_lc_steady", 1'b0, 1'b1, H_L, H_C);
        cyc(1); check();
        exp_state("s2_unlock", S_IDLE);
        cyc(1); pass_valid = 1'b0; check();
        exp_out("s2_off", 1'b0, 1'b0, H_OFF, H_OFF);
        exp_occ("s2_occ", 2'd1, 1'b0);
        cyc(1); check();

        // password-entry timeout
        sensor_entrance = 1'b1;
        exp_state("s3_wait", S_WAIT);
        cyc(1); sensor_entrance = 1'b0; check();
        cyc(30);
        exp_state("s3_wait_last", S_WAIT);
        cyc(1); check();
        exp_state("s3_timeout", S_IDLE);
        cyc(1); check();
        exp_out("s3_off", 1'b0, 1'b0, H_OFF, H_OFF);
        exp_occ("s3_occ", 2'd1, 1'b0);
        cyc(1); check();

        // tailgate -> STOP, wrong strobe ignored, correct strobe back; blink rate
        sensor_entrance = 1'b1;
        cyc(1);
        sensor_entrance = 1'b0;
        strobe(2'b01, 2'b10);
        exp_state("s4_right", S_RIGHT);
        cyc(1); pass_valid = 1'b0; check();
        sensor_entrance = 1'b1; sensor_exit = 1'b1;
        exp_state("s4_stop", S_STOP);
        cyc(1); sensor_entrance = 1'b0; sensor_exit = 1'b0; check();
        strobe(2'b00, 2'b00);
        exp_out("s4_sp", 1'b0, 1'b1, H_S, H_P);
        cyc(1); pass_valid = 1'b0; check();
        exp_state("s4_stop_kept", S_STOP);
        exp_out("s4_red_on", 1'b0, 1'b1, H_S, H_P);
        cyc(1); check();
        cyc(2);
        exp_out("s4_red_off", 1'b0, 1'b0, H_S, H_P);
        cyc(1); check();
        strobe(2'b01, 2'b10);
        exp_state("s4_back_right", S_RIGHT);
        cyc(1); pass_valid = 1'b0; check();
        exp_out("s4_green_c1", 1'b1, 1'b0, H_G, H_O);
        cyc(1); check();
        cyc(2);
        exp_out("s4_green_c4", 1'b1, 1'b0, H_G, H_O);
        cyc(1); check();
        exp_out("s4_green_c5", 1'b0, 1'b0, H_G, H_O);
        cyc(1); check();
        cyc(2);
        exp_out("s4_green_c8", 1'b0, 1'b0, H_G, H_O);
        cyc(1); check();
        exp_out("s4_green_c9", 1'b1, 1'b0, H_G, H_O);
        cyc(1); check();
        sensor_exit = 1'b1;
        exp_state("s4_idle", S_IDLE);
        cyc(1); sensor_exit = 1'b0; check();
        exp_occ("s4_occ_full", 2'd2, 1'b1);
        exp_out("s4_off", 1'b0, 1'b0, H_OFF, H_OFF);
        cyc(1); check();

        // lot full refusal, car leaves, entry resumes
        sensor_entrance = 1'b1;
        exp_state("s5_full", S_FULL);
        cyc(1); check();
        exp_out("s5_fl", 1'b0, 1'b1, H_F, H_L);
        cyc(1); check();
        car_leave = 1'b1;
        exp_state("s5_full_hold", S_FULL);
        exp_occ("s5_leave", 2'd1, 1'b0);
        cyc(1); car_leave = 1'b0; check();
        exp_state("s5_idle", S_IDLE);
        cyc(1); check();
        exp_state("s5_wait", S_WAIT);
        cyc(1); check();
        sensor_entrance = 1'b0;
        strobe(2'b01, 2'b10);
        exp_state("s5_right", S_RIGHT);
        cyc(1); pass_valid = 1'b0; check();
        sensor_exit = 1'b1; car_leave = 1'b1;
        exp_state("s5_idle2", S_IDLE);
        cyc(1); sensor_exit = 1'b0; car_leave = 1'b0; check();
        exp_occ("s5_admit_leave", 2'd1, 1'b0);
        cyc(1); check();

        // asynchronous reset mid-operation
        sensor_entrance = 1'b1;
        cyc(2);
        sensor_entrance = 1'b0;
        #2 reset = 1'b1;
        #1;
        exp_state("s6_rst_state", S_IDLE);
        exp_out("s6_rst_panel", 1'b0, 1'b0, H_OFF, H_OFF);
        exp_occ("s6_rst_occ", 2'd0, 1'b0);
        check();
        cyc(1);
        reset = 1'b0;

        // departure at zero occupancy saturates
        car_leave = 1'b1;
        exp_occ("s7_floor", 2'd0, 1'b0);
        exp_state("s7_idle", S_IDLE);
        cyc(2); car_leave = 1'b0; check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
